pix_frame_writer: RTL and testbench
===================================

# pix_frame_writer

Sink for the edge-detection pipeline's 8-pixel output stream. It accepts beats from the pipeline's `out_valid`/`pix_out` with no backpressure and buffers them in an internal FIFO. Each beat is written to a word-addressed frame-buffer write port with a valid/ready handshake. The block tracks raster position, tags line and frame boundaries, and pulses `frame_done` once the last beat of a frame has been written.

## Interface
- `WIDTH`, default 640: pixels per line; a multiple of `LANES`.
- `HEIGHT`, default 480: lines per frame.
- `LANES`, default 8: pixels per beat.
- `PIX_W`, default 8: bits per pixel.
- `FIFO_DEPTH`, default 16: beat entries; a power of two, at least 4.
- `ADDR_W`, default 16: word address width; must hold `HEIGHT*WIDTH/LANES - 1`.
- `clk`  in  1  clock; all logic is on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clr`  in  1  synchronous clear: empties the FIFO and zeroes the counters and `overflow`.
- `in_valid`  in  1  pipeline beat valid; there is no ready.
- `pix_in`  in  LANES*PIX_W  beat data; lane 0 is in bits [PIX_W-1:0] and is the leftmost pixel.
- `mem_wr_en`  out  1  write request.
- `mem_wr_ready`  in  1  memory accepts the write this cycle.
- `mem_addr`  out  ADDR_W  beat index within the frame.
- `mem_wdata`  out  LANES*PIX_W  beat data.
- `mem_sof`  out  1  current write is beat 0 of the frame.
- `mem_eol`  out  1  current write is the last beat of a line.
- `frame_done`  out  1  one-cycle pulse after the frame's last write.
- `overflow`  out  1  sticky: at least one beat was dropped.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Definitions: BPL = WIDTH/LANES beats per line; BPF = BPL*HEIGHT beats per frame.
- Push: when `in_valid`=1 and the FIFO is not full, the beat is written to the FIFO.
- Full FIFO with `in_valid`=1: the beat is dropped and `overflow` is set. `overflow` clears only on reset or `clr`.
- Push and pop in the same cycle on a full FIFO: the push is accepted and the level is unchanged.
- Pop: occurs when `mem_wr_en`=1 and `mem_wr_ready`=1 (a transfer).
- Stability: while `mem_wr_en`=1 and `mem_wr_ready`=0, all of `mem_addr`, `mem_wdata`, `mem_sof` and `mem_eol` hold stable.
- Write-side counters:
  - `xb` counts 0..BPL-1 and `y` counts 0..HEIGHT-1.
  - Each transfer increments `xb`. At `xb`=BPL-1, `xb` goes to 0 and `y` increments.
  - `mem_addr` = y*BPL + xb, implemented as a single running counter 0..BPF-1, not a multiply.
  - `mem_sof` = (`mem_addr`==0); `mem_eol` = (`xb`==BPL-1).
- FSM states:
  - IDLE: the FIFO is empty and `mem_wr_en`=0. Go to WRITE when the FIFO becomes non-empty.
  - WRITE: `mem_wr_en`=1 whenever the FIFO is non-empty.
    - A transfer at `mem_addr`=BPF-1 goes to DONE and wraps all counters to 0.
    - Otherwise, when the FIFO becomes empty, go to IDLE.
  - DONE: lasts exactly one cycle, with `frame_done`=1 and `mem_wr_en`=0. Pushes continue. Next state is WRITE if the FIFO is non-empty, else IDLE.
- Inter-frame beats: beats arriving after a frame ends belong to the next frame, starting at address 0.
- `clr` takes priority over every event in the same cycle: a coincident beat is dropped, and `overflow` is not set by it. The next state is IDLE.
- Reset values: state IDLE; `mem_wr_en`, `mem_sof`, `mem_eol`, `frame_done`, `overflow` all 0; `mem_addr`=0, `mem_wdata`=0, `fifo_level`=0.
- Reset mid-frame: all queued beats are discarded, and the next write starts at address 0.

## Timing
- Latency:
  - A beat pushed at edge N into an empty FIFO in IDLE is presented with `mem_wr_en`=1 after edge N+1.
  - If `mem_wr_ready`=1, it transfers at edge N+2.
- Throughput: one transfer per cycle when `mem_wr_ready`=1 and the FIFO is non-empty. DONE costs one bubble per frame.
- Outputs: all outputs are registered.
- `fifo_level` reflects pushes and pops completed at the previous edge.

## Test plan
- Streaming, WIDTH=32, HEIGHT=2 (BPL=4, BPF=8), `mem_wr_ready` held at 1, 8 consecutive beats with data 0x01..0x08:
  - Writes go to addresses 0..7 with matching data.
  - `mem_sof` is 1 at address 0 only; `mem_eol` is 1 at addresses 3 and 7.
  - `frame_done` pulses once, one cycle after the address-7 transfer; overflow stays 0.
- Backpressure: `mem_wr_ready` toggles with pattern 1,0,0,1,…
  - Address and data hold stable through every stall; no beat is lost or duplicated.
  - The final `fifo_level` is 0.
- Overflow, FIFO_DEPTH=4, `mem_wr_ready`=0, 6 beats pushed:
  - `fifo_level` saturates at 4 and `overflow` becomes 1.
  - After `mem_wr_ready` is released, exactly beats 1..4 are written at addresses 0..3.
- Back-to-back frames, with 10 beats sent continuously:
  - Beat 9 is written to address 0 with `mem_sof`=1 after the single DONE bubble.
  - Beat 10 is written to address 1.
- `clr` asserted with `in_valid`=1 mid-frame, 3 beats queued:
  - The FIFO empties, `overflow` is 0 and the coincident beat is dropped.
  - The next beat is written at address 0.
- Asynchronous `rst_n` asserted mid-write: all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pix_frame_writer.sv
// Buffers pipeline beats in a FIFO and writes them to a frame buffer with raster address and sof/eol tags.
// Latency: push to presented write in 2 edges; input has no backpressure (full FIFO drops), mem_wr_ready stalls writes.
module pix_frame_writer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int LANES      = 8,
    parameter int PIX_W      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             in_valid,
    input  logic [LANES*PIX_W-1:0]           pix_in,
    output logic                             mem_wr_en,
    input  logic                             mem_wr_ready,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [LANES*PIX_W-1:0]           mem_wdata,
    output logic                             mem_sof,
    output logic                             mem_eol,
    output logic                             frame_done,
    output logic                             overflow,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

    localparam int DW  = LANES * PIX_W;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int BPL = WIDTH / LANES;
    localparam int BPF = BPL * HEIGHT;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              en_q, en_d, sof_q, sof_d, eol_q, eol_d;
    logic              done_q, done_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0] addr_q, addr_d, xb_q, xb_d;
    logic [DW-1:0]     wdata_q, wdata_d, head_next;
    logic              xfer, full, push;

    assign xfer = en_q & mem_wr_ready;
    assign full = (level_q == LW'(FIFO_DEPTH));
    assign push = in_valid & ~clr & (~full | xfer);

    // Head after a pop: the next stored entry, or the beat being pushed right now if none is stored.
    assign head_next = (level_q > LW'(1)) ? mem_q[rd_ptr_q + PW'(1)] : pix_in;

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        xb_d     = xb_q;
        done_d   = 1'b0;
        level_d  = level_q + LW'(push) - LW'(xfer);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(xfer);
        ovf_d    = ovf_q | (in_valid & full & ~xfer);

        if (xfer) begin
            if (addr_q == ADDR_W'(BPF - 1)) begin
                addr_d = '0;
                xb_d   = '0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
                xb_d   = (xb_q == ADDR_W'(BPL - 1)) ? '0 : xb_q + ADDR_W'(1);
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (level_q != '0) begin
                    state_d = S_WRITE;
                    en_d    = 1'b1;
                    wdata_d = mem_q[rd_ptr_q];
                end else begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                end
            end
            S_WRITE: begin
                if (xfer) begin
                    if (addr_q == ADDR_W'(BPF - 1)) begin
                        state_d = S_DONE;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                    end else if (level_d != '0) begin
                        en_d    = 1'b1;
                        wdata_d = head_next;
                    end else begin
                        state_d = S_IDLE;
                        en_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase

        if (clr) begin
            state_d  = S_IDLE;
            en_d     = 1'b0;
            wdata_d  = '0;
            addr_d   = '0;
            xb_d     = '0;
            done_d   = 1'b0;
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end

        sof_d = en_d & (addr_d == '0);
        eol_d = en_d & (xb_d == ADDR_W'(BPL - 1));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            wdata_q  <= '0;
            addr_q   <= '0;
            xb_q     <= '0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            xb_q     <= xb_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign mem_wr_en  = en_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_sof    = sof_q;
    assign mem_eol    = eol_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_pix_frame_writer.sv
// Directed bench for pix_frame_writer: 4 beats/line, 2 lines/frame, 4-entry FIFO.
module tb_pix_frame_writer;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, mem_wr_ready;
    logic [63:0] pix_in;
    logic        mem_wr_en, mem_sof, mem_eol, frame_done, overflow;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    pix_frame_writer #(
        .WIDTH(32), .HEIGHT(2), .LANES(8), .PIX_W(8), .FIFO_DEPTH(4), .ADDR_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .pix_in(pix_in),
        .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sof(mem_sof), .mem_eol(mem_eol),
        .frame_done(frame_done), .overflow(overflow), .fifo_level(fifo_level)
    );

    typedef struct {
        logic [15:0] a;
        logic [63:0] d;
        logic        s;
        logic        e;
        int          cyc;
    } wr_t;

    wr_t         wq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          fd_cnt = 0;
    int          fd_cyc = 0;
    logic        stall_p = 1'b0;
    logic [15:0] a_p;
    logic [63:0] d_p;
    logic        s_p, e_p;

    function automatic logic [63:0] pat(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {8{b}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected: n writes, addresses counting 0..7 and wrapping, data pat(dbase+i).
    task automatic chk_seq(input string tag, input int n, input int dbase);
        chk({tag, ".count"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wq.size()) begin
                int a;
                a = i % 8;
                chk($sformatf("%s.addr[%0d]", tag, i), 64'(wq[i].a), 64'(a));
                chk($sformatf("%s.data[%0d]", tag, i), wq[i].d, pat(dbase + i));
                chk($sformatf("%s.sof[%0d]", tag, i), 64'(wq[i].s), 64'(a == 0));
                chk($sformatf("%s.eol[%0d]", tag, i), 64'(wq[i].e), 64'(a % 4 == 3));
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (stall_p && rst_n) begin
            checks++;
            assert (mem_wr_en === 1'b1 && mem_addr === a_p && mem_wdata === d_p &&
                    mem_sof === s_p && mem_eol === e_p) else begin
                failures++;
                $error("FAIL stall_hold observed=%0h/%0h expected=%0h/%0h", mem_addr, mem_wdata, a_p, d_p);
            end
        end
        stall_p = rst_n && !clr && mem_wr_en && !mem_wr_ready;
        a_p = mem_addr;
        d_p = mem_wdata;
        s_p = mem_sof;
        e_p = mem_eol;
        if (rst_n && !clr && mem_wr_en && mem_wr_ready)
            wq.push_back('{a: mem_addr, d: mem_wdata, s: mem_sof, e: mem_eol, cyc: cyc});
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    initial begin
        int sent;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; mem_wr_ready = 1'b0; pix_in = '0;
        tick(); tick();
        chk("rst.en", 64'(mem_wr_en), 0);
        chk("rst.addr", 64'(mem_addr), 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.sof", 64'(mem_sof), 0);
        chk("rst.eol", 64'(mem_eol), 0);
        chk("rst.done", 64'(frame_done), 0);
        chk("rst.ovf", 64'(overflow), 0);
        chk("rst.level", 64'(fifo_level), 0);
        rst_n = 1'b1;
        tick();

        // Streaming frame
        wq.delete(); fd_cnt = 0; mem_wr_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; pix_in = pat(k);
            tick();
            if (k == 1) begin
                chk("lat.en_n1", 64'(mem_wr_en), 0);
                chk("lat.level_n1", 64'(fifo_level), 1);
            end
            if (k == 2) begin
                chk("lat.en_n2", 64'(mem_wr_en), 1);
                chk("lat.wdata_n2", mem_wdata, pat(1));
                chk("lat.sof_n2", 64'(mem_sof), 1);
            end
        end
        in_valid = 1'b0;
        repeat (15) tick();
        chk_seq("stream", 8, 1);
        chk("stream.fd_cnt", 64'(fd_cnt), 1);
        if (wq.size() == 8) chk("stream.fd_cyc", 64'(fd_cyc), 64'(wq[7].cyc + 1));
        chk("stream.ovf", 64'(overflow), 0);

        // Backpressure 1,0,0,...
        wq.delete(); fd_cnt = 0; sent = 0;
        for (int c = 0; c < 60; c++) begin
            mem_wr_ready = (c % 3 == 0);
            if (c % 3 == 0 && sent < 8) begin
                sent++;
                in_valid = 1'b1; pix_in = pat(8'h20 + sent);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0; mem_wr_ready = 1'b1;
        repeat (10) tick();
        chk_seq("bp", 8, 8'h21);
        chk("bp.level", 64'(fifo_level), 0);
        chk("bp.fd_cnt", 64'(fd_cnt), 1);
        chk("bp.ovf", 64'(overflow), 0);

        // Overflow: 6 beats into a 4-entry FIFO with memory stalled
        wq.delete(); mem_wr_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1; pix_in = pat(8'h30 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("ovf.level", 64'(fifo_level), 4);
        chk("ovf.flag", 64'(overflow), 1);
        chk("ovf.head", mem_wdata, pat(8'h31));
        mem_wr_ready = 1'b1;
        repeat (10) tick();
        chk_seq("ovf", 4, 8'h31);
        chk("ovf.level_end", 64'(fifo_level), 0);
        chk("ovf.sticky", 64'(overflow), 1);

        // clr mid-frame with 3 queued beats and a coincident beat
        mem_wr_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; pix_in = pat(8'h50 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("clr.level_pre", 64'(fifo_level), 3);
        chk("clr.addr_pre", 64'(mem_addr), 4);
        clr = 1'b1; in_valid = 1'b1; pix_in = pat(8'h5f);
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr.level", 64'(fifo_level), 0);
        chk("clr.ovf", 64'(overflow), 0);
        chk("clr.en", 64'(mem_wr_en), 0);
        chk("clr.addr", 64'(mem_addr), 0);
        tick();
        chk("clr.dropped", 64'(fifo_level), 0);
        wq.delete(); mem_wr_ready = 1'b1;
        in_valid = 1'b1; pix_in = pat(8'h61);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk_seq("clr_next", 1, 8'h61);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Back-to-back frames: 10 continuous beats
        wq.delete(); fd_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; pix_in = pat(8'h40 + k);
            tick();
        end
        in_valid = 1'b0;
        repeat (15) tick();
        chk_seq("b2b", 10, 8'h41);
        chk("b2b.fd_cnt", 64'(fd_cnt), 1);
        if (wq.size() >= 9) begin
            chk("b2b.fd_cyc", 64'(fd_cyc), 64'(wq[7].cyc + 1));
            chk("b2b.bubble", 64'(wq[8].cyc), 64'(wq[7].cyc + 2));
        end

        // Asynchronous reset while a write is presented
        mem_wr_ready = 1'b0;
        in_valid = 1'b1; pix_in = pat(8'h71);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("arst.en_pre", 64'(mem_wr_en), 1);
        chk("arst.addr_pre", 64'(mem_addr), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.en", 64'(mem_wr_en), 0);
        chk("arst.addr", 64'(mem_addr), 0);
        chk("arst.wdata", mem_wdata, 0);
        chk("arst.level", 64'(fifo_level), 0);
        chk("arst.sof", 64'(mem_sof), 0);
        chk("arst.eol", 64'(mem_eol), 0);
        chk("arst.done", 64'(frame_done), 0);
        chk("arst.ovf", 64'(overflow), 0);
        tick();
        rst_n = 1'b1;
        tick();
        wq.delete(); mem_wr_ready = 1'b1;
        in_valid = 1'b1; pix_in = pat(8'h81);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk_seq("arst_next", 1, 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
